pc_exception_unit: RTL
======================

Name: pc_exception_unit

Overview:
- Owns the program counter and the error-return state of the multi-cycle CPU.
- Sits directly downstream of the controller FSM and consumes PCWrite, PCWriteCond, PCSource, PCErrSource, EPCWrite and ErrTarget write strobes.
- Returns Err (the trap request) to the controller.
- Holds PC, EPC, ErrTarget and the in-handler flag; computes next PC from the datapath sources.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset
- ERR_VECTOR, 32'h8000_0004, handler entry on first-level error
- DFAULT_VECTOR, 32'h8000_0008, handler entry on error raised while already in handler

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- PCWrite  in  1  unconditional PC update
- PCWriteCond  in  1  PC update qualified by Zero
- Zero  in  1  ALU zero flag
- PCSource  in  2  normal next-PC select
- PCErrSource  in  2  error next-PC select
- EPCWrite  in  1  latch EPC on error entry
- ErrTargetWrite  in  1  latch faulting address
- Overflow  in  1  ALU signed overflow, current cycle
- TrapEn  in  1  overflow trapping enabled (0 for addiu/addu/sltiu class)
- ALUResult  in  32  combinational ALU output (PC+4 in fetch)
- ALUOut  in  32  registered ALU output (branch target)
- InstrIndex  in  26  instruction[25:0]
- RegA  in  32  rs register value (jr/jalr)
- PC  out  32  current PC
- EPC  out  32  return address
- ErrTarget  out  32  faulting instruction address, for register writeback
- Err  out  1  trap request to controller
- InHandler  out  1  error handler active
- DoubleFault  out  1  sticky, error raised inside handler
- Misaligned  out  1  sticky, target with nonzero [1:0] was written

Behaviour:
- Reset (sync, reset=1 at rising edge):
  - PC=RESET_PC; EPC=0; ErrTarget=0; InHandler=0; DoubleFault=0; Misaligned=0.
  - reset overrides every other input in that cycle.
- Err = Overflow & TrapEn, combinational, zero latency; it is not masked by InHandler.
- Update enable: pc_en = PCWrite | (PCWriteCond & Zero). Without pc_en, PC holds.
- Next-PC when PCErrSource=00:
  - PCSource 00 → ALUResult
  - PCSource 01 → ALUOut
  - PCSource 10 → {PC[31:28], InstrIndex, 2'b00}
  - PCSource 11 → RegA
- Next-PC when PCErrSource=01:
  - ERR_VECTOR if InHandler=0.
  - DFAULT_VECTOR if InHandler=1; DoubleFault is set the same edge.
- Next-PC when PCErrSource=10: EPC (error return).
- PCErrSource=11 is reserved: PC holds even with pc_en=1.
- PCErrSource and PCSource are don't-care when pc_en=0.
- Alignment:
  - Selected target is written with bits[1:0] forced to 00.
  - If the raw target had nonzero [1:0], Misaligned is set (sticky until reset).
- Error entry (EPCWrite=1, InHandler=0):
  - EPC<=PC (already PC+4 of faulting instruction).
  - InHandler<=1 on the same edge.
- ErrTargetWrite=1 (InHandler=0): ErrTarget<=PC-32'd4, modulo 2^32 (PC=0 gives FFFF_FFFC).
- EPCWrite or ErrTargetWrite while InHandler=1: EPC and ErrTarget keep their values.
- Error return (pc_en & PCErrSource=10):
  - PC<=EPC; InHandler<=0 on the same edge.
  - DoubleFault is not cleared.
- Simultaneous error return and EPCWrite in one cycle: EPCWrite is ignored; the return wins.
- Sticky flags clear only on reset.
- All register updates take effect the cycle after the strobe (1-cycle latency). PC output is the register, never the mux.

Decomposition:
- Shared package cpu_defs holds:
  - PCSource encodings: PCSRC_SEQ, PCSRC_BR, PCSRC_J, PCSRC_JR.
  - PCErrSource encodings: PCERR_NONE, PCERR_ENTER, PCERR_RET, PCERR_RSVD.
  - Default vectors.
- One sub-module, next_pc_mux: purely combinational target select plus the misalign flag.
- All state lives in pc_exception_unit.

Test Plan:
- Reset then fetch:
  - reset=1 for 1 cycle, then PCWrite=1, PCSource=00, ALUResult=4 → PC=0 during reset release, PC=4 next cycle.
- Branch:
  - PCWriteCond=1, Zero=0, ALUOut=0x40 → PC holds.
  - Repeat with Zero=1 → PC=0x40.
- Jump and jr misalign:
  - PC=0x1000_0010, PCSource=10, InstrIndex=0x000_0100 → PC=0x1000_0400.
  - Then PCSource=11, RegA=0x203 → PC=0x200, Misaligned=1.
- Error entry and return:
  - PC=0x24, Overflow=1, TrapEn=1 → Err=1.
  - Strobe PCWrite+PCErrSource=01+EPCWrite+ErrTargetWrite → PC=0x8000_0004, EPC=0x24, ErrTarget=0x20, InHandler=1.
  - Later PCWrite+PCErrSource=10 → PC=0x24, InHandler=0.
- Double fault:
  - While InHandler=1, repeat the error-entry strobes → PC=0x8000_0008, EPC still 0x24, DoubleFault=1 and still 1 after error return.
- Reset mid-handler:
  - InHandler=1, DoubleFault=1, assert reset with PCWrite=1 → all outputs return to reset values next edge.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU encodings for next-PC / error-PC selection and default trap vectors.
package cpu_defs;
  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_J   = 2'b10,
    PCSRC_JR  = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    PCERR_NONE  = 2'b00,
    PCERR_ENTER = 2'b01,
    PCERR_RET   = 2'b10,
    PCERR_RSVD  = 2'b11
  } pcerr_e;

  localparam logic [31:0] DEF_RESET_PC      = 32'h0000_0000;
  localparam logic [31:0] DEF_ERR_VECTOR    = 32'h8000_0004;
  localparam logic [31:0] DEF_DFAULT_VECTOR = 32'h8000_0008;
endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC target select; reports whether the raw target was misaligned.
module next_pc_mux
  import cpu_defs::*;
#(
  parameter logic [31:0] ERR_VECTOR    = DEF_ERR_VECTOR,
  parameter logic [31:0] DFAULT_VECTOR = DEF_DFAULT_VECTOR
) (
  input  logic [31:0] pc,
  input  logic [31:0] epc,
  input  logic        in_handler,
  input  logic [1:0]  pc_source,
  input  logic [1:0]  pc_err_source,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out,
  input  logic [25:0] instr_index,
  input  logic [31:0] reg_a,
  output logic [31:0] target,
  output logic        misalign,
  output logic        valid
);
  logic [31:0] raw;

  always_comb begin
    raw   = alu_result;
    valid = 1'b1;
    case (pc_err_source)
      PCERR_NONE: begin
        case (pc_source)
          PCSRC_SEQ: raw = alu_result;
          PCSRC_BR:  raw = alu_out;
          PCSRC_J:   raw = {pc[31:28], instr_index, 2'b00};
          default:   raw = reg_a;
        endcase
      end
      PCERR_ENTER: raw = in_handler ? DFAULT_VECTOR : ERR_VECTOR;
      PCERR_RET:   raw = epc;
      default: begin
        raw   = pc;
        valid = 1'b0;
      end
    endcase
  end

  assign target   = {raw[31:2], 2'b00};
  assign misalign = valid & (raw[1:0] != 2'b00);
endmodule

// File: rtl/pc_exception_unit.sv
// Program counter plus error-return state (EPC, ErrTarget, handler and sticky fault flags).
module pc_exception_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC      = DEF_RESET_PC,
  parameter logic [31:0] ERR_VECTOR    = DEF_ERR_VECTOR,
  parameter logic [31:0] DFAULT_VECTOR = DEF_DFAULT_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        PCWriteCond,
  input  logic        Zero,
  input  logic [1:0]  PCSource,
  input  logic [1:0]  PCErrSource,
  input  logic        EPCWrite,
  input  logic        ErrTargetWrite,
  input  logic        Overflow,
  input  logic        TrapEn,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ALUOut,
  input  logic [25:0] InstrIndex,
  input  logic [31:0] RegA,
  output logic [31:0] PC,
  output logic [31:0] EPC,
  output logic [31:0] ErrTarget,
  output logic        Err,
  output logic        InHandler,
  output logic        DoubleFault,
  output logic        Misaligned
);
  logic [31:0] pc_q, epc_q, err_target_q, target;
  logic        in_handler_q, double_fault_q, misaligned_q;
  logic        misalign, tgt_valid, pc_en, do_write, err_ret, dfault, enter;

  next_pc_mux #(
    .ERR_VECTOR   (ERR_VECTOR),
    .DFAULT_VECTOR(DFAULT_VECTOR)
  ) u_mux (
    .pc           (pc_q),
    .epc          (epc_q),
    .in_handler   (in_handler_q),
    .pc_source    (PCSource),
    .pc_err_source(PCErrSource),
    .alu_result   (ALUResult),
    .alu_out      (ALUOut),
    .instr_index  (InstrIndex),
    .reg_a        (RegA),
    .target       (target),
    .misalign     (misalign),
    .valid        (tgt_valid)
  );

  assign pc_en    = PCWrite | (PCWriteCond & Zero);
  assign do_write = pc_en & tgt_valid;
  assign err_ret  = pc_en & (PCErrSource == PCERR_RET);
  assign dfault   = pc_en & (PCErrSource == PCERR_ENTER) & in_handler_q;
  // An error return in the same cycle suppresses error entry.
  assign enter    = EPCWrite & ~in_handler_q & ~err_ret;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q           <= RESET_PC;
      epc_q          <= '0;
      err_target_q   <= '0;
      in_handler_q   <= 1'b0;
      double_fault_q <= 1'b0;
      misaligned_q   <= 1'b0;
    end else begin
      if (do_write) pc_q <= target;
      if (do_write & misalign) misaligned_q <= 1'b1;
      if (dfault) double_fault_q <= 1'b1;
      if (enter) epc_q <= pc_q;
      if (ErrTargetWrite & ~in_handler_q) err_target_q <= pc_q - 32'd4;
      if (err_ret) in_handler_q <= 1'b0;
      else if (enter) in_handler_q <= 1'b1;
    end
  end

  assign PC          = pc_q;
  assign EPC         = epc_q;
  assign ErrTarget   = err_target_q;
  assign Err         = Overflow & TrapEn;
  assign InHandler   = in_handler_q;
  assign DoubleFault = double_fault_q;
  assign Misaligned  = misaligned_q;
endmodule
